// File: rtl/fx2_chan_pkg.sv
// Shared types, constants and address decode for the FPGALink channel router.
package fx2_chan_pkg;

  localparam int CHAN_IDX_W = 3;
  localparam int MAX_CHAN   = 8;

  typedef enum logic [1:0] {
    STAT_MASK  = 2'd0,
    STAT_VALID = 2'd1,
    STAT_DROP  = 2'd2
  } stat_idx_e;

  localparam logic [7:0] DROP_FILL = 8'hFF;
  localparam logic [7:0] DROP_MAX  = 8'd255;

  typedef struct packed {
    logic                  hit;
    logic [CHAN_IDX_W-1:0] index;
  } chan_dec_t;

  function automatic chan_dec_t chan_decode(input logic [6:0] addr,
                                            input int         base_addr,
                                            input int         num_chan);
    chan_dec_t dec;
    dec = '0;
    for (int k = 0; k < MAX_CHAN; k++) begin
      if ((k < num_chan) && (int'(addr) == base_addr + k)) begin
        dec.hit   = 1'b1;
        dec.index = CHAN_IDX_W'(k);
      end
    end
    return dec;
  endfunction

endpackage

// File: rtl/fx2_chan_pipe_reg.sv
// One-entry tagged pipeline register; the tag travels with the byte so a
// held entry always drains to the destination it was accepted for.
module fx2_chan_pipe_reg #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              load_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              drain_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign ready_o = !full_q || drain_i;
  assign full_o  = full_q;
  assign tag_o   = tag_q;
  assign data_o  = data_q;

  // A load in the same cycle as a drain replaces the entry: 1 byte/clk.
  always_comb begin
    full_d = full_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      tag_d  = tag_i;
      data_d = data_i;
    end else if (full_q && drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      full_q <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fx2_chan_router.sv
// Routes comm_fpga_fx2 channel traffic to NUM_CHAN application channels and
// serves a status/control channel (enable mask, drop counter).
module fx2_chan_router
  import fx2_chan_pkg::*;
#(
  parameter int NUM_CHAN    = 4,
  parameter int BASE_ADDR   = 0,
  parameter int STATUS_ADDR = 127
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [6:0]            chanAddr_in,
  input  logic [7:0]            h2fData_in,
  input  logic                  h2fValid_in,
  output logic                  h2fReady_out,
  output logic [7:0]            f2hData_out,
  output logic                  f2hValid_out,
  input  logic                  f2hReady_in,
  output logic [8*NUM_CHAN-1:0] chH2fData_out,
  output logic [NUM_CHAN-1:0]   chH2fValid_out,
  input  logic [NUM_CHAN-1:0]   chH2fReady_in,
  input  logic [8*NUM_CHAN-1:0] chF2hData_in,
  input  logic [NUM_CHAN-1:0]   chF2hValid_in,
  output logic [NUM_CHAN-1:0]   chF2hReady_out
);

  chan_dec_t              dec;
  logic                   is_stat, chan_en;
  logic                   transfer, load, h2f_drop, f2h_drop, stat_pop, drop_clr;
  logic [7:0]             mask_ext, rdy_ext, f2hv_ext;
  logic [NUM_CHAN-1:0]    mask_q, mask_d;
  logic [7:0]             drop_q, drop_d;
  logic [8:0]             drop_sum;
  stat_idx_e              stat_q, stat_d;
  logic                   pipe_full;
  logic [CHAN_IDX_W-1:0]  pipe_tag;
  logic [7:0]             pipe_data;

  assign dec      = chan_decode(chanAddr_in, BASE_ADDR, NUM_CHAN);
  assign is_stat  = (chanAddr_in == 7'(STATUS_ADDR));
  assign mask_ext = 8'(mask_q);
  assign rdy_ext  = 8'(chH2fReady_in);
  assign f2hv_ext = 8'(chF2hValid_in);
  assign chan_en  = dec.hit && mask_ext[dec.index];

  assign transfer = h2fValid_in && h2fReady_out;
  assign load     = transfer && chan_en;
  assign h2f_drop = transfer && !is_stat && !chan_en;
  assign f2h_drop = f2hReady_in && !is_stat && !chan_en;
  assign stat_pop = f2hReady_in && is_stat;
  assign drop_clr = stat_pop && (stat_q == STAT_DROP);

  fx2_chan_pipe_reg #(.TAG_W(CHAN_IDX_W), .DATA_W(8)) u_pipe (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .load_i   (load),
    .tag_i    (dec.index),
    .data_i   (h2fData_in),
    .drain_i  (rdy_ext[pipe_tag]),
    .ready_o  (h2fReady_out),
    .full_o   (pipe_full),
    .tag_o    (pipe_tag),
    .data_o   (pipe_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHAN; gi++) begin : g_h2f
      assign chH2fValid_out[gi]     = pipe_full && (pipe_tag == CHAN_IDX_W'(gi));
      assign chH2fData_out[8*gi+:8] = chH2fValid_out[gi] ? pipe_data : 8'h00;
    end
  endgenerate

  // Unselected or disabled sources are never popped; the host sees fill bytes.
  always_comb begin
    f2hValid_out   = 1'b1;
    f2hData_out    = DROP_FILL;
    chF2hReady_out = '0;
    if (is_stat) begin
      case (stat_q)
        STAT_MASK:  f2hData_out = mask_ext;
        STAT_VALID: f2hData_out = f2hv_ext;
        default:    f2hData_out = drop_q;
      endcase
    end else if (chan_en) begin
      f2hValid_out = f2hv_ext[dec.index];
      for (int k = 0; k < NUM_CHAN; k++) begin
        if (dec.index == CHAN_IDX_W'(k)) begin
          f2hData_out       = chF2hData_in[8*k+:8];
          chF2hReady_out[k] = f2hReady_in;
        end
      end
    end
  end

  always_comb begin
    stat_d = stat_q;
    if (!is_stat) begin
      stat_d = STAT_MASK;
    end else if (stat_pop) begin
      case (stat_q)
        STAT_MASK:  stat_d = STAT_VALID;
        STAT_VALID: stat_d = STAT_DROP;
        default:    stat_d = STAT_MASK;
      endcase
    end
  end

  always_comb begin
    mask_d   = mask_q;
    drop_sum = {1'b0, drop_q} + 9'(h2f_drop) + 9'(f2h_drop);
    if (transfer && is_stat) begin
      mask_d = h2fData_in[NUM_CHAN-1:0];
    end
    if (drop_clr) begin
      drop_d = 8'h00;
    end else if (drop_sum > {1'b0, DROP_MAX}) begin
      drop_d = DROP_MAX;
    end else begin
      drop_d = drop_sum[7:0];
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      mask_q <= '1;
      drop_q <= 8'h00;
      stat_q <= STAT_MASK;
    end else begin
      mask_q <= mask_d;
      drop_q <= drop_d;
      stat_q <= stat_d;
    end
  end

endmodule

// File: tb/tb_fx2_chan_router.sv
// Directed bench for fx2_chan_router with hand-computed expectations.
module tb_fx2_chan_router;

  localparam int NC = 4;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic [6:0]      chanAddr_in;
  logic [7:0]      h2fData_in;
  logic            h2fValid_in;
  logic            h2fReady_out;
  logic [7:0]      f2hData_out;
  logic            f2hValid_out;
  logic            f2hReady_in;
  logic [8*NC-1:0] chH2fData_out;
  logic [NC-1:0]   chH2fValid_out;
  logic [NC-1:0]   chH2fReady_in;
  logic [8*NC-1:0] chF2hData_in;
  logic [NC-1:0]   chF2hValid_in;
  logic [NC-1:0]   chF2hReady_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] stream_bytes [3] = '{8'h11, 8'h22, 8'h33};

  fx2_chan_router #(.NUM_CHAN(NC), .BASE_ADDR(0), .STATUS_ADDR(127)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .chanAddr_in    (chanAddr_in),
    .h2fData_in     (h2fData_in),
    .h2fValid_in    (h2fValid_in),
    .h2fReady_out   (h2fReady_out),
    .f2hData_out    (f2hData_out),
    .f2hValid_out   (f2hValid_out),
    .f2hReady_in    (f2hReady_in),
    .chH2fData_out  (chH2fData_out),
    .chH2fValid_out (chH2fValid_out),
    .chH2fReady_in  (chH2fReady_in),
    .chF2hData_in   (chF2hData_in),
    .chF2hValid_in  (chF2hValid_in),
    .chF2hReady_out (chF2hReady_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    reset_in      = 1'b0;
    chanAddr_in   = 7'd0;
    h2fData_in    = 8'h00;
    h2fValid_in   = 1'b0;
    f2hReady_in   = 1'b0;
    chH2fReady_in = 4'hF;
    chF2hData_in  = '0;
    chF2hValid_in = '0;
    #2;
    check("rst_h2f_ready", 32'(h2fReady_out), 32'h1);
    check("rst_ch_valid", 32'(chH2fValid_out), 32'h0);
    check("rst_ch_data", 32'(chH2fData_out), 32'h0);
    tick;
    tick;
    reset_in = 1'b1;

    // Streaming to channel 1 at full rate
    chanAddr_in = 7'd1;
    h2fValid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      h2fData_in = stream_bytes[i];
      #1;
      check("stream_ready", 32'(h2fReady_out), 32'h1);
      tick;
      check("stream_valid", 32'(chH2fValid_out), 32'h2);
      check("stream_data", 32'(chH2fData_out[15:8]), 32'(stream_bytes[i]));
    end
    h2fValid_in = 1'b0;
    tick;
    check("stream_idle", 32'(chH2fValid_out), 32'h0);

    // Backpressure on channel 2; tag must survive an address change
    chH2fReady_in = 4'b1011;
    chanAddr_in   = 7'd2;
    h2fData_in    = 8'hA5;
    h2fValid_in   = 1'b1;
    tick;
    chanAddr_in = 7'd0;
    h2fData_in  = 8'h5A;
    #1;
    check("hold_ready", 32'(h2fReady_out), 32'h0);
    check("hold_valid", 32'(chH2fValid_out), 32'h4);
    check("hold_data", 32'(chH2fData_out[23:16]), 32'hA5);
    tick;
    check("hold_still", 32'(chH2fValid_out), 32'h4);
    chH2fReady_in = 4'hF;
    #1;
    check("release_ready", 32'(h2fReady_out), 32'h1);
    tick;
    check("next_valid", 32'(chH2fValid_out), 32'h1);
    check("next_data", 32'(chH2fData_out[7:0]), 32'h5A);
    h2fValid_in = 1'b0;
    tick;
    check("drain_idle", 32'(chH2fValid_out), 32'h0);

    // Mask write (upper bits ignored), then write to disabled channel 1
    chanAddr_in = 7'd127;
    h2fData_in  = 8'hF5;
    h2fValid_in = 1'b1;
    tick;
    chanAddr_in = 7'd1;
    h2fData_in  = 8'h77;
    tick;
    h2fValid_in = 1'b0;
    check("dis_drop_valid", 32'(chH2fValid_out), 32'h0);
    tick;
    check("dis_drop_valid2", 32'(chH2fValid_out), 32'h0);

    // Status readout cycle
    chF2hValid_in = 4'b0011;
    chanAddr_in   = 7'd127;
    f2hReady_in   = 1'b1;
    #1;
    check("stat_mask", 32'(f2hData_out), 32'h05);
    check("stat_fvalid", 32'(f2hValid_out), 32'h1);
    tick;
    check("stat_bitmap", 32'(f2hData_out), 32'h03);
    tick;
    check("stat_drop1", 32'(f2hData_out), 32'h01);
    tick;
    check("stat_wrap", 32'(f2hData_out), 32'h05);
    f2hReady_in = 1'b0;

    // f2h from disabled channel 1 and enabled channel 0
    chF2hValid_in = 4'b0010;
    chF2hData_in  = 32'h0000_3CC3;
    chanAddr_in   = 7'd1;
    f2hReady_in   = 1'b1;
    #1;
    check("dis_f2h_data", 32'(f2hData_out), 32'hFF);
    check("dis_f2h_valid", 32'(f2hValid_out), 32'h1);
    check("dis_f2h_pop", 32'(chF2hReady_out), 32'h0);
    tick;
    chanAddr_in = 7'd0;
    #1;
    check("en_f2h_data", 32'(f2hData_out), 32'hC3);
    check("en_f2h_valid", 32'(f2hValid_out), 32'h0);
    check("en_f2h_pop", 32'(chF2hReady_out), 32'h1);

    // Simultaneous h2f and f2h drop on unmapped address: +2
    chanAddr_in = 7'd64;
    h2fValid_in = 1'b1;
    h2fData_in  = 8'h00;
    tick;
    h2fValid_in = 1'b0;
    chanAddr_in = 7'd127;
    tick;
    tick;
    check("stat_drop3", 32'(f2hData_out), 32'h03);
    tick;
    f2hReady_in = 1'b0;

    // Saturation after 300 unmapped writes, then clear on read
    chanAddr_in = 7'd64;
    h2fValid_in = 1'b1;
    repeat (300) tick;
    check("unmapped_ready", 32'(h2fReady_out), 32'h1);
    h2fValid_in = 1'b0;
    chanAddr_in = 7'd127;
    f2hReady_in = 1'b1;
    tick;
    tick;
    check("drop_sat", 32'(f2hData_out), 32'hFF);
    tick;
    tick;
    tick;
    check("drop_clr", 32'(f2hData_out), 32'h00);
    f2hReady_in = 1'b0;

    // Async reset while a byte is held
    chH2fReady_in = 4'b1110;
    chanAddr_in   = 7'd0;
    h2fData_in    = 8'h99;
    h2fValid_in   = 1'b1;
    tick;
    h2fValid_in = 1'b0;
    check("pre_rst_valid", 32'(chH2fValid_out), 32'h1);
    #2;
    reset_in = 1'b0;
    #1;
    check("async_rst_valid", 32'(chH2fValid_out), 32'h0);
    check("async_rst_data", 32'(chH2fData_out), 32'h0);
    check("async_rst_ready", 32'(h2fReady_out), 32'h1);
    tick;
    reset_in    = 1'b1;
    chanAddr_in = 7'd127;
    f2hReady_in = 1'b1;
    #1;
    check("post_rst_mask", 32'(f2hData_out), 32'h0F);
    tick;
    tick;
    check("post_rst_drop", 32'(f2hData_out), 32'h00);
    f2hReady_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
